// File: rtl/reg_if_mem_bridge.sv
// reg_if_mem_bridge: turns single-outstanding register read/write requests into
// timed accesses to a synchronous sim RAM, with programmable extra latency.
// Optional feature macro: REG_MEM_RAND_STALL_EN (LFSR-driven random counter stalls).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for an armed request; write wins over read
// WR_CNT   | write latency countdown
// WR_ISS   | wen pulse to RAM, reg_wr_ack in the same cycle
// RD_CNT   | read latency countdown
// RD_ISS   | ren pulse to RAM with latched address
// RD_CAP   | RAM rdata valid, registered into reg_rd_data
// RD_ACK   | reg_rd_ack pulse with registered data
module reg_if_mem_bridge #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 128,
  parameter int          STRB_WIDTH = DATA_WIDTH / 8,
  parameter int          RD_LAT     = 2,
  parameter int          WR_LAT     = 1,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reg_wr_en,
  input  logic [ADDR_WIDTH-1:0] reg_wr_addr,
  input  logic [DATA_WIDTH-1:0] reg_wr_data,
  input  logic [STRB_WIDTH-1:0] reg_wr_strb,
  output logic                  reg_wr_wait,
  output logic                  reg_wr_ack,
  input  logic                  reg_rd_en,
  input  logic [ADDR_WIDTH-1:0] reg_rd_addr,
  output logic [DATA_WIDTH-1:0] reg_rd_data,
  output logic                  reg_rd_wait,
  output logic                  reg_rd_ack,
  output logic                  ren,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [STRB_WIDTH-1:0] wstrb
);

  localparam int CNT_W = 8;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WR_CNT = 3'd1;
  localparam logic [2:0] S_WR_ISS = 3'd2;
  localparam logic [2:0] S_RD_CNT = 3'd3;
  localparam logic [2:0] S_RD_ISS = 3'd4;
  localparam logic [2:0] S_RD_CAP = 3'd5;
  localparam logic [2:0] S_RD_ACK = 3'd6;

  localparam logic [CNT_W-1:0] WR_LOAD = (WR_LAT == 0) ? '0 : CNT_W'(WR_LAT - 1);
  localparam logic [CNT_W-1:0] RD_LOAD = (RD_LAT == 0) ? '0 : CNT_W'(RD_LAT - 1);

  logic [2:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic                  wr_arm;
  logic                  rd_arm;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [STRB_WIDTH-1:0] strb_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  wr_go;
  logic                  rd_go;
  logic                  wr_cap;
  logic                  rd_cap;
  logic                  cnt_tick;
  logic                  wr_skip;
  logic                  rd_skip;

`ifdef REG_MEM_RAND_STALL_EN
  logic [15:0] lfsr;

  // Galois LFSR x^16+x^14+x^13+x^11+1, stepping every cycle
  always_ff @(posedge clk) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  // zero latency still spends at least one stall-able count cycle
  assign cnt_tick = ~lfsr[0];
  assign wr_skip  = 1'b0;
  assign rd_skip  = 1'b0;
`else
  assign cnt_tick = 1'b1;
  assign wr_skip  = (WR_LAT == 0);
  assign rd_skip  = (RD_LAT == 0);
`endif

  assign wr_go  = reg_wr_en & wr_arm;
  assign rd_go  = reg_rd_en & rd_arm & ~wr_go;
  assign wr_cap = (state == S_IDLE) & wr_go;
  assign rd_cap = (state == S_IDLE) & rd_go;

  // main sequencing FSM with latency down-counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (wr_go) begin
            cnt   <= WR_LOAD;
            state <= wr_skip ? S_WR_ISS : S_WR_CNT;
          end else if (rd_go) begin
            cnt   <= RD_LOAD;
            state <= rd_skip ? S_RD_ISS : S_RD_CNT;
          end
        end
        S_WR_CNT: begin
          if (cnt_tick) begin
            if (cnt == '0) state <= S_WR_ISS;
            else           cnt   <= cnt - CNT_W'(1);
          end
        end
        S_WR_ISS: state <= S_IDLE;
        S_RD_CNT: begin
          if (cnt_tick) begin
            if (cnt == '0) state <= S_RD_ISS;
            else           cnt   <= cnt - CNT_W'(1);
          end
        end
        S_RD_ISS: state <= S_RD_CAP;
        S_RD_CAP: state <= S_RD_ACK;
        S_RD_ACK: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // arm flags: cleared on capture, re-armed once the master drops its enable
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_arm <= 1'b1;
      rd_arm <= 1'b1;
    end else begin
      if (wr_cap)          wr_arm <= 1'b0;
      else if (!reg_wr_en) wr_arm <= 1'b1;
      if (rd_cap)          rd_arm <= 1'b0;
      else if (!reg_rd_en) rd_arm <= 1'b1;
    end
  end

  // request fields latched at capture; one shared address register serves both channels
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      data_q <= '0;
      strb_q <= '0;
    end else if (wr_cap) begin
      addr_q <= reg_wr_addr;
      data_q <= reg_wr_data;
      strb_q <= reg_wr_strb;
    end else if (rd_cap) begin
      addr_q <= reg_rd_addr;
    end
  end

  // RAM read data captured one cycle after ren, held until the next read
  always_ff @(posedge clk) begin
    if (rst)                    rd_data_q <= '0;
    else if (state == S_RD_CAP) rd_data_q <= rdata;
  end

  assign wen         = (state == S_WR_ISS);
  assign reg_wr_ack  = (state == S_WR_ISS);
  assign ren         = (state == S_RD_ISS);
  assign reg_rd_ack  = (state == S_RD_ACK);
  assign waddr       = addr_q;
  assign wdata       = data_q;
  assign wstrb       = strb_q;
  assign raddr       = addr_q;
  assign reg_rd_data = rd_data_q;
  assign reg_wr_wait = reg_wr_en & ~reg_wr_ack;
  assign reg_rd_wait = reg_rd_en & ~reg_rd_ack;

endmodule

// File: tb/tb_reg_if_mem_bridge.sv
// Testbench for reg_if_mem_bridge: main instance at default latencies plus a
// zero-latency instance; each has its own synchronous RAM model. Expected data
// comes from a shadow memory updated with the requested strobes.
module tb_reg_if_mem_bridge;

  localparam int RL     = 2;
  localparam int WL     = 1;
  localparam int BUDGET = 300;
`ifdef REG_MEM_RAND_STALL_EN
  localparam int NRAND = 1000;
`else
  localparam int NRAND = 60;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en, rd_en, z_wr_en, z_rd_en;
  logic [31:0]  wr_addr, rd_addr;
  logic [127:0] wr_data;
  logic [15:0]  wr_strb;

  logic         wr_wait, wr_ack, rd_wait, rd_ack, ren, wen;
  logic [127:0] rd_data, rdata, wdata;
  logic [31:0]  raddr, waddr;
  logic [15:0]  wstrb;

  logic         z_wr_wait, z_wr_ack, z_rd_wait, z_rd_ack, z_ren, z_wen;
  logic [127:0] z_rd_data, z_rdata, z_wdata;
  logic [31:0]  z_raddr, z_waddr;
  logic [15:0]  z_wstrb;

  int checks   = 0;
  int failures = 0;

  logic [127:0] ram    [logic [31:0]];
  logic [127:0] z_ram  [logic [31:0]];
  logic [127:0] shadow [logic [31:0]];

  wire [5:0] flags   = {wen, wr_ack, wr_wait, ren, rd_ack, rd_wait};
  wire [5:0] z_flags = {z_wen, z_wr_ack, z_wr_wait, z_ren, z_rd_ack, z_rd_wait};

  always #5 clk = ~clk;

  reg_if_mem_bridge #(.RD_LAT(RL), .WR_LAT(WL)) dut (
    .clk(clk), .rst(rst),
    .reg_wr_en(wr_en), .reg_wr_addr(wr_addr), .reg_wr_data(wr_data), .reg_wr_strb(wr_strb),
    .reg_wr_wait(wr_wait), .reg_wr_ack(wr_ack),
    .reg_rd_en(rd_en), .reg_rd_addr(rd_addr), .reg_rd_data(rd_data),
    .reg_rd_wait(rd_wait), .reg_rd_ack(rd_ack),
    .ren(ren), .raddr(raddr), .rdata(rdata),
    .wen(wen), .waddr(waddr), .wdata(wdata), .wstrb(wstrb)
  );

  reg_if_mem_bridge #(.RD_LAT(0), .WR_LAT(0)) dut0 (
    .clk(clk), .rst(rst),
    .reg_wr_en(z_wr_en), .reg_wr_addr(wr_addr), .reg_wr_data(wr_data), .reg_wr_strb(wr_strb),
    .reg_wr_wait(z_wr_wait), .reg_wr_ack(z_wr_ack),
    .reg_rd_en(z_rd_en), .reg_rd_addr(rd_addr), .reg_rd_data(z_rd_data),
    .reg_rd_wait(z_rd_wait), .reg_rd_ack(z_rd_ack),
    .ren(z_ren), .raddr(z_raddr), .rdata(z_rdata),
    .wen(z_wen), .waddr(z_waddr), .wdata(z_wdata), .wstrb(z_wstrb)
  );

  function automatic logic [127:0] merge(input logic [127:0] old, input logic [127:0] nw,
                                         input logic [15:0] s);
    logic [127:0] r;
    r = old;
    for (int b = 0; b < 16; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [127:0] shadow_rd(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : 128'h0;
  endfunction

  // synchronous RAM models: write on wen, read data valid the cycle after ren
  always @(posedge clk) begin
    logic [127:0] t;
    if (wen) begin
      t = ram.exists(waddr) ? ram[waddr] : 128'h0;
      ram[waddr] = merge(t, wdata, wstrb);
    end
    if (ren) rdata <= ram.exists(raddr) ? ram[raddr] : 128'h0;
  end

  always @(posedge clk) begin
    logic [127:0] t;
    if (z_wen) begin
      t = z_ram.exists(z_waddr) ? z_ram[z_waddr] : 128'h0;
      z_ram[z_waddr] = merge(t, z_wdata, z_wstrb);
    end
    if (z_ren) z_rdata <= z_ram.exists(z_raddr) ? z_ram[z_raddr] : 128'h0;
  end

  task automatic do_write(input logic [31:0] a, input logic [127:0] d, input logic [15:0] s);
    bit done = 0;
    int lat = WL + 1;
    @(posedge clk); #1;
    wr_addr = a; wr_data = d; wr_strb = s; wr_en = 1'b1;
    shadow[a] = merge(shadow_rd(a), d, s);
    for (int k = 0; k < BUDGET && !done; k++) begin
      @(negedge clk);
`ifndef REG_MEM_RAND_STALL_EN
      checks++;
      if (flags !== {1'(k == lat), 1'(k == lat), 1'(k < lat), 3'b000}) begin
        failures++;
        $display("FAIL wr_timing k=%0d got %b expected %b", k, flags,
                 {1'(k == lat), 1'(k == lat), 1'(k < lat), 3'b000});
      end
`endif
      if (wr_ack) begin
        checks++;
        if ({waddr, wdata, wstrb} !== {a, d, s}) begin
          failures++;
          $display("FAIL wr_fields got %h/%h/%h expected %h/%h/%h", waddr, wdata, wstrb, a, d, s);
        end
        done = 1;
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL wr_timeout got no ack expected ack within %0d cycles", BUDGET);
    end
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a);
    bit done = 0;
    int lat = RL + 3;
    logic [127:0] expd;
    expd = shadow_rd(a);
    @(posedge clk); #1;
    rd_addr = a; rd_en = 1'b1;
    for (int k = 0; k < BUDGET && !done; k++) begin
      @(negedge clk);
`ifndef REG_MEM_RAND_STALL_EN
      checks++;
      if (flags !== {3'b000, 1'(k == RL + 1), 1'(k == lat), 1'(k < lat)}) begin
        failures++;
        $display("FAIL rd_timing k=%0d got %b expected %b", k, flags,
                 {3'b000, 1'(k == RL + 1), 1'(k == lat), 1'(k < lat)});
      end
`endif
      if (ren) begin
        checks++;
        if (raddr !== a) begin
          failures++;
          $display("FAIL rd_addr got %h expected %h", raddr, a);
        end
      end
      if (rd_ack) begin
        checks++;
        if (rd_data !== expd) begin
          failures++;
          $display("FAIL rd_data addr=%h got %h expected %h", a, rd_data, expd);
        end
        done = 1;
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL rd_timeout got no ack expected ack within %0d cycles", BUDGET);
    end
    @(posedge clk); #1;
    rd_en = 1'b0;
    @(negedge clk);
    checks++;
    if (rd_data !== expd || rd_ack !== 1'b0) begin
      failures++;
      $display("FAIL rd_hold got %h ack=%b expected %h ack=0", rd_data, rd_ack, expd);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; wr_en = 0; rd_en = 0; z_wr_en = 0; z_rd_en = 0;
    wr_addr = '0; rd_addr = '0; wr_data = '0; wr_strb = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({flags, waddr, wdata, wstrb, raddr, rd_data, z_flags} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got flags=%b waddr=%h rd_data=%h expected all zero",
               flags, waddr, rd_data);
    end
  endtask

  task automatic test_defaults;
    do_write(32'h10, 128'hDEADBEEF, 16'hFFFF);
    do_read(32'h10);
  endtask

  task automatic test_simultaneous;
    logic [127:0] d;
    int wa = WL + 1;
    int rp = WL + 2 + RL + 1;
    int ra = WL + 2 + RL + 3;
    bit done = 0;
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    shadow[32'h20] = merge(shadow_rd(32'h20), d, 16'hFFFF);
    @(posedge clk); #1;
    wr_addr = 32'h20; wr_data = d; wr_strb = 16'hFFFF; wr_en = 1'b1;
    rd_addr = 32'h20; rd_en = 1'b1;
    for (int k = 0; k < 30 && !done; k++) begin
      @(negedge clk);
      checks++;
      if (flags !== {1'(k == wa), 1'(k == wa), 1'(k < wa), 1'(k == rp), 1'(k == ra), 1'(k < ra)}) begin
        failures++;
        $display("FAIL simul_timing k=%0d got %b expected %b", k, flags,
                 {1'(k == wa), 1'(k == wa), 1'(k < wa), 1'(k == rp), 1'(k == ra), 1'(k < ra)});
      end
      if (rd_ack) begin
        checks++;
        if (rd_data !== d) begin
          failures++;
          $display("FAIL simul_data got %h expected %h", rd_data, d);
        end
      end
      @(posedge clk); #1;
      if (k == wa) wr_en = 1'b0;
      if (k == ra) begin rd_en = 1'b0; done = 1; end
    end
  endtask

  task automatic test_hold;
    int lat = RL + 3;
    @(posedge clk); #1;
    rd_addr = 32'h10; rd_en = 1'b1;
    for (int k = 0; k <= lat + 6; k++) begin
      @(negedge clk);
      checks++;
      if ({ren, rd_ack, rd_wait} !== {1'(k == RL + 1), 1'(k == lat), 1'(k <= lat + 2 && k != lat)}) begin
        failures++;
        $display("FAIL hold k=%0d got %b expected %b", k, {ren, rd_ack, rd_wait},
                 {1'(k == RL + 1), 1'(k == lat), 1'(k <= lat + 2 && k != lat)});
      end
      @(posedge clk); #1;
      if (k == lat + 2) rd_en = 1'b0;
    end
    do_read(32'h10);
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    rd_addr = 32'h20; rd_en = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      checks++;
      if (ren !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_ren k=%0d got %b expected 0", k, ren);
      end
      if (k == 3) begin
        checks++;
        if ({flags, waddr, wdata, wstrb, raddr, rd_data} !== '0) begin
          failures++;
          $display("FAIL reset_mid_outputs got flags=%b raddr=%h rd_data=%h expected all zero",
                   flags, raddr, rd_data);
        end
      end
      @(posedge clk); #1;
      if (k == 1) begin rst = 1'b1; rd_en = 1'b0; end
      if (k == 2) rst = 1'b0;
    end
    shadow.delete();
    ram.delete();
    do_write(32'h30, 128'h0123_4567_89AB_CDEF, 16'h00FF);
    do_read(32'h30);
  endtask

  task automatic test_zero_latency;
    logic [127:0] d;
    bit done = 0;
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    @(posedge clk); #1;
    wr_addr = 32'h40; wr_data = d; wr_strb = 16'hFFFF; z_wr_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (z_flags !== {1'(k == 1), 1'(k == 1), 1'(k < 1), 3'b000}) begin
        failures++;
        $display("FAIL zero_wr k=%0d got %b expected %b", k, z_flags, {1'(k == 1), 1'(k == 1), 1'(k < 1), 3'b000});
      end
      @(posedge clk); #1;
      if (k == 1) z_wr_en = 1'b0;
    end
    rd_addr = 32'h40; z_rd_en = 1'b1;
    for (int k = 0; k < 6 && !done; k++) begin
      @(negedge clk);
      checks++;
      if (z_flags !== {3'b000, 1'(k == 1), 1'(k == 3), 1'(k < 3)}) begin
        failures++;
        $display("FAIL zero_rd k=%0d got %b expected %b", k, z_flags, {3'b000, 1'(k == 1), 1'(k == 3), 1'(k < 3)});
      end
      if (z_rd_ack) begin
        checks++;
        if (z_rd_data !== d) begin
          failures++;
          $display("FAIL zero_rd_data got %h expected %h", z_rd_data, d);
        end
        done = 1;
      end
      @(posedge clk); #1;
      if (k == 3) z_rd_en = 1'b0;
    end
  endtask

  task automatic test_random;
    logic [31:0] a;
    for (int i = 0; i < NRAND; i++) begin
      a = {24'h0, 4'($urandom_range(0, 15)), 4'h0};
      if ($urandom_range(0, 1) == 0)
        do_write(a, {$urandom(), $urandom(), $urandom(), $urandom()}, 16'($urandom()));
      else
        do_read(a);
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
`ifndef REG_MEM_RAND_STALL_EN
    test_simultaneous();
    test_hold();
    test_reset_mid();
    test_zero_latency();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
